// File: rtl/feature_add_feeder.sv
// Producer for the residual feature-add path: buffers the shortcut (x1) and conv (x2)
// streams, issues lane-aligned pairs to the adder, and tracks task completion.

module feature_add_feeder_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic             system_clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge system_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

module feature_add_feeder #(
  parameter int FEATURE_WIDTH = 8,
  parameter int FIFO_DEPTH    = 8,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                       system_clk,
  input  logic                       rst_n,
  input  logic                       task_start,
  input  logic [CNT_WIDTH-1:0]       task_word_num,
  input  logic [2:0]                 task_relative_quant,
  input  logic                       task_relative_quant_polar,
  input  logic                       task_over_flow,
  input  logic [FEATURE_WIDTH*8-1:0] x1_data_in,
  input  logic                       x1_valid_in,
  output logic                       x1_ready_out,
  input  logic [FEATURE_WIDTH*8-1:0] x2_data_in,
  input  logic                       x2_valid_in,
  output logic                       x2_ready_out,
  output logic [FEATURE_WIDTH*8-1:0] feature_x1_out,
  output logic [FEATURE_WIDTH*8-1:0] feature_x2_out,
  output logic                       feature_x_valid_out,
  output logic [2:0]                 fea_relative_quant,
  output logic                       fea_relative_quant_polar,
  output logic                       fea_over_flow,
  input  logic                       feature_data_valid_in,
  output logic                       busy,
  output logic                       task_done,
  output logic [1:0]                 fsm_state
);
  localparam int DW = FEATURE_WIDTH * 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic                 done_nxt;
  logic [CNT_WIDTH-1:0] word_num;
  logic [CNT_WIDTH-1:0] acc1_cnt, acc2_cnt, issue_cnt, ret_cnt, ret_cnt_nxt;
  logic                 x1_full, x1_empty, x2_full, x2_empty;
  logic [DW-1:0]        x1_head, x2_head;
  logic                 push1, push2, pop, start_ok, ret_inc;

  // Handshake: a word transfers on a cycle where valid and ready are both high.
  // Ready depends only on registered state, never on valid or on this cycle's pop.
  assign x1_ready_out = (state == RUN) && !x1_full && (acc1_cnt < word_num);
  assign x2_ready_out = (state == RUN) && !x2_full && (acc2_cnt < word_num);
  assign push1        = x1_valid_in && x1_ready_out;
  assign push2        = x2_valid_in && x2_ready_out;
  assign pop          = (state == RUN) && !x1_empty && !x2_empty && (issue_cnt < word_num);

  assign busy        = (state != IDLE);
  assign fsm_state   = state;
  assign start_ok    = (state == IDLE) && task_start;
  assign ret_inc     = busy && feature_data_valid_in;
  assign ret_cnt_nxt = ret_cnt + CNT_WIDTH'(ret_inc);

  feature_add_feeder_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_x1_fifo (
    .system_clk (system_clk),
    .rst_n      (rst_n),
    .push       (push1),
    .din        (x1_data_in),
    .pop        (pop),
    .dout       (x1_head),
    .full       (x1_full),
    .empty      (x1_empty)
  );

  feature_add_feeder_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_x2_fifo (
    .system_clk (system_clk),
    .rst_n      (rst_n),
    .push       (push2),
    .din        (x2_data_in),
    .pop        (pop),
    .dout       (x2_head),
    .full       (x2_full),
    .empty      (x2_empty)
  );

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (task_start) begin
          if (task_word_num == '0) done_nxt  = 1'b1;
          else                     state_nxt = RUN;
        end
      end
      RUN: begin
        if (pop && (issue_cnt + CNT_WIDTH'(1) == word_num)) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (ret_cnt_nxt >= word_num) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      word_num  <= '0;
      acc1_cnt  <= '0;
      acc2_cnt  <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else if (start_ok) begin
      word_num  <= task_word_num;
      acc1_cnt  <= '0;
      acc2_cnt  <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else begin
      if (push1) acc1_cnt  <= acc1_cnt + CNT_WIDTH'(1);
      if (push2) acc2_cnt  <= acc2_cnt + CNT_WIDTH'(1);
      if (pop)   issue_cnt <= issue_cnt + CNT_WIDTH'(1);
      ret_cnt <= ret_cnt_nxt;
    end
  end

  // Config stays frozen from task_start until the next start seen in IDLE.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      fea_relative_quant       <= '0;
      fea_relative_quant_polar <= 1'b0;
      fea_over_flow            <= 1'b0;
    end else if (start_ok) begin
      fea_relative_quant       <= task_relative_quant;
      fea_relative_quant_polar <= task_relative_quant_polar;
      fea_over_flow            <= task_over_flow;
    end
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      feature_x1_out      <= '0;
      feature_x2_out      <= '0;
      feature_x_valid_out <= 1'b0;
      task_done           <= 1'b0;
    end else begin
      feature_x_valid_out <= pop;
      task_done           <= done_nxt;
      if (pop) begin
        feature_x1_out <= x1_head;
        feature_x2_out <= x2_head;
      end
    end
  end
endmodule
